fifo_prog_sync: RTL and testbench
=================================

Name: fifo_prog_sync

Overview:
- Single-clock synchronous FIFO; the next generation of the team's basic FIFO.
- Adds any (non power-of-two) depth, run-time almost-full/almost-empty thresholds, an occupancy output, sticky overflow/underflow flags, and a compile-time read mode (show-ahead or registered).
- Sits between producer and consumer blocks inside one clock domain.

Parameters:
- DEPTH, 16, number of entries; any integer >= 2.
- DATA_WIDTH, 8, entry width in bits.
- FWFT, 1, read mode: 1 = show-ahead (head visible without pop); 0 = registered read (data appears after pop).
- CW, clog2(DEPTH+1) (derived localparam), width of level and threshold buses.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_push  in  1  write request.
- i_data  in  DATA_WIDTH  write data.
- i_pop  in  1  read request.
- o_data  out  DATA_WIDTH  read data.
- i_afull_thr  in  CW  almost-full threshold.
- i_aempty_thr  in  CW  almost-empty threshold.
- i_clr_err  in  1  clears sticky error flags.
- o_full  out  1  level == DEPTH.
- o_empty  out  1  level == 0.
- o_almost_full  out  1  level >= i_afull_thr.
- o_almost_empty  out  1  level <= i_aempty_thr.
- o_level  out  CW  current occupancy.
- o_overflow  out  1  sticky: push was rejected.
- o_underflow  out  1  sticky: pop was rejected.

Behaviour:
- State: write pointer, read pointer, level register. Pointers are binary 0..DEPTH-1 and wrap from DEPTH-1 to 0 (not modulo 2^n).
- Push acceptance: push_ok = i_push & (!full | pop_ok).
- Pop acceptance: pop_ok = i_pop & !empty.
- Full + push + pop: both accepted; level unchanged.
- Empty + push + pop: push accepted, pop rejected; o_underflow set.
- Level update: +1 on push_ok only; -1 on pop_ok only; unchanged otherwise. The level never exceeds DEPTH or goes below 0.
- Flags: o_full, o_empty, o_almost_full and o_almost_empty decode combinationally from the level register only (no input dependence). All flags reflect an accepted operation on the next cycle.
- Thresholds are sampled live and compared unsigned. i_afull_thr = 0 forces o_almost_full = 1. i_aempty_thr >= DEPTH forces o_almost_empty = 1.
- Errors:
  - o_overflow sets on (i_push & !push_ok); o_underflow sets on (i_pop & !pop_ok).
  - Both stay set until i_clr_err. If a set and a clear occur in the same cycle, the set wins.
  - A rejected push leaves memory and pointers untouched.
- Memory: written at posedge on push_ok at the write pointer; no reset on the array.
- FWFT=1: o_data = mem[rd_ptr] when !o_empty, else all zeros. A new entry becomes visible the cycle after its push.
- FWFT=0: o_data is a register, loaded with mem[rd_ptr] on pop_ok, so data is valid the cycle after the pop. It holds its value otherwise, including after the FIFO becomes empty.
- Reset values (asynchronous): pointers 0, level 0, o_empty 1, o_full 0, o_almost_empty 1, o_almost_full = (i_afull_thr == 0), o_overflow 0, o_underflow 0, o_data 0.
- Reset asserted mid-operation discards all contents immediately. The first push after deassertion lands in entry 0.

Optional Feature:
- Macro FIFO_WATERMARK_EN.
- Defined: adds output o_max_level (CW bits) holding the peak level since reset or since the last i_clr_err. It updates on the cycle after the level rises above the stored peak. i_clr_err loads the current level, not 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package fifo_pkg holds:
  - the clog2 constant function;
  - a next-pointer wrap function (ptr == DEPTH-1 ? 0 : ptr+1).
- Sub-module fifo_mem_dp: DEPTH x DATA_WIDTH array with one synchronous write port and one asynchronous read port.
- Control, level, flags and the read register stay in fifo_prog_sync.

Test Plan:
- Reset, DEPTH=5, thresholds afull=4 / aempty=1 -> level 0; empty=1, full=0, aempty=1, afull=0, errors 0.
- Push 5 values 0xA1..0xA5 (DEPTH=5) -> level 1..5; afull rises at level 4; full at 5. Pop 5 -> 0xA1..0xA5 in order; pointer wraps 4->0 with no data loss.
- Full and push 0xFF without pop -> o_overflow=1, level stays 5, 0xFF never read. Then i_clr_err -> o_overflow=0 the next cycle.
- Full with push 0xB0 and pop in the same cycle -> level stays 5; 0xB0 is read fifth afterwards.
- Empty with push 0xC3 and pop -> o_underflow=1, level 1. FWFT=1: o_data=0xC3 the next cycle. FWFT=0: o_data holds its prior value until a pop.
- FIFO_WATERMARK_EN: push 3, pop 2, push 1 -> o_max_level=3. i_clr_err at level 2 -> o_max_level=2.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the programmable synchronous FIFO family.
// Holds the constant-function log2 used to size buses and the pointer
// wrap function that lets the FIFO use depths that are not powers of two.
package fifo_pkg;

    // Number of bits needed to encode values 0..value-1 (at least 0).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 32'd0;
        rem    = (value > 32'd0) ? (value - 32'd1) : 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (rem != 32'd0) begin
                result = result + 32'd1;
                rem    = rem >> 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Advance a binary pointer, wrapping from depth-1 back to 0.
    function automatic int unsigned next_ptr(input int unsigned ptr,
                                             input int unsigned depth);
        return (ptr == (depth - 32'd1)) ? 32'd0 : (ptr + 32'd1);
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem_dp.sv
// Storage array for fifo_prog_sync: DEPTH x DATA_WIDTH entries with one
// synchronous write port and one asynchronous read port. The array itself
// carries no reset; validity of its contents is tracked by the controller.
module fifo_mem_dp
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned AW         = clog2(DEPTH)
)(
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write the addressed entry on an accepted push.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule : fifo_mem_dp

// File: rtl/fifo_prog_sync.sv
// Single-clock FIFO with arbitrary depth, live almost-full/almost-empty
// thresholds, occupancy output and sticky overflow/underflow flags.
// FWFT=1 presents the head entry without a pop; FWFT=0 registers read data
// on each accepted pop and holds it otherwise.
// Optional build macro FIFO_WATERMARK_EN adds o_max_level, the peak
// occupancy since reset or since the last error clear.
module fifo_prog_sync
    import fifo_pkg::*;
#(
    parameter  int unsigned DEPTH      = 16,
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned FWFT       = 32'd1,
    localparam int unsigned CW         = clog2(DEPTH + 32'd1)
)(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic [CW-1:0]         i_afull_thr,
    input  logic [CW-1:0]         i_aempty_thr,
    input  logic                  i_clr_err,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [CW-1:0]         o_level,
    output logic                  o_overflow,
    output logic                  o_underflow
`ifdef FIFO_WATERMARK_EN
    ,
    output logic [CW-1:0]         o_max_level
`endif
);

    localparam int unsigned PW = clog2(DEPTH);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         level_q,  level_d;
    logic                  ovf_q,    ovf_d;
    logic                  udf_q,    udf_d;
    logic                  full_s;
    logic                  empty_s;
    logic                  push_ok_s;
    logic                  pop_ok_s;
    logic [DATA_WIDTH-1:0] mem_rdata_s;

    fifo_mem_dp #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (PW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (push_ok_s),
        .i_waddr (wr_ptr_q),
        .i_wdata (i_data),
        .i_raddr (rd_ptr_q),
        .o_rdata (mem_rdata_s)
    );

    // Status flags decode only from the stored level so they never depend on inputs.
    always_comb begin
        full_s         = (level_q == CW'(DEPTH));
        empty_s        = (level_q == {CW{1'b0}});
        o_almost_full  = (level_q >= i_afull_thr);
        o_almost_empty = (level_q <= i_aempty_thr);
    end

    assign o_full      = full_s;
    assign o_empty     = empty_s;
    assign o_level     = level_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = udf_q;

    // Accept a pop only when data exists; a push into a full FIFO is allowed only
    // when a pop frees an entry in the same cycle.
    always_comb begin
        pop_ok_s  = i_pop & ~empty_s;
        push_ok_s = i_push & (~full_s | pop_ok_s);
    end

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        if (push_ok_s) begin
            wr_ptr_d = PW'(next_ptr(32'(wr_ptr_q), DEPTH));
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_ok_s) begin
            rd_ptr_d = PW'(next_ptr(32'(rd_ptr_q), DEPTH));
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   level_d = level_q - {{(CW-1){1'b0}}, 1'b1};
            default: level_d = level_q;
        endcase

        // A new error in the same cycle as a clear must survive the clear.
        if (i_push & ~push_ok_s) begin
            ovf_d = 1'b1;
        end else if (i_clr_err) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        if (i_pop & ~pop_ok_s) begin
            udf_d = 1'b1;
        end else if (i_clr_err) begin
            udf_d = 1'b0;
        end else begin
            udf_d = udf_q;
        end
    end

    // Control state registers; reset drops all contents at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            level_q  <= {CW{1'b0}};
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    generate
        if (FWFT != 32'd0) begin : g_show_ahead
            // Head entry is visible directly; zeros are driven while empty.
            assign o_data = empty_s ? {DATA_WIDTH{1'b0}} : mem_rdata_s;
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

            // Capture the head on each accepted pop, hold it otherwise.
            always_comb begin
                if (pop_ok_s) begin
                    rdata_d = mem_rdata_s;
                end else begin
                    rdata_d = rdata_q;
                end
            end

            // Read data register.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    rdata_q <= {DATA_WIDTH{1'b0}};
                end else begin
                    rdata_q <= rdata_d;
                end
            end

            assign o_data = rdata_q;
        end
    endgenerate

`ifdef FIFO_WATERMARK_EN
    logic [CW-1:0] max_q, max_d;

    // Track the peak level; a clear restarts tracking from the present level.
    always_comb begin
        if (i_clr_err) begin
            max_d = level_q;
        end else if (level_q > max_q) begin
            max_d = level_q;
        end else begin
            max_d = max_q;
        end
    end

    // Peak level register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            max_q <= {CW{1'b0}};
        end else begin
            max_q <= max_d;
        end
    end

    assign o_max_level = max_q;
`endif

endmodule : fifo_prog_sync

// File: tb/tb_fifo_prog_sync.sv
// Self-checking bench for fifo_prog_sync. Two instances (show-ahead and
// registered read, DEPTH=5) share one stimulus stream; a queue-based model
// predicts occupancy, flags, read data and sticky errors.
module tb_fifo_prog_sync;

    localparam int DEPTH = 5;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          push = 1'b0;
    logic [7:0]    din = 8'h00;
    logic          pop = 1'b0;
    logic [CW-1:0] afull_thr = 3'd4;
    logic [CW-1:0] aempty_thr = 3'd1;
    logic          clr_err = 1'b0;

    logic [7:0]    f_data, r_data;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic          r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
    logic [CW-1:0] f_level, r_level;
`ifdef FIFO_WATERMARK_EN
    logic [CW-1:0] f_max, r_max;
    int            m_max;
`endif

    logic [7:0]    mq[$];
    bit            m_ovf, m_udf;
    logic [7:0]    m_reg;
    int            errors = 0;
    int            checks = 0;

    fifo_prog_sync #(.DEPTH(DEPTH), .DATA_WIDTH(8), .FWFT(1)) dut_fw (
        .i_clk(clk), .i_rst_n(rst_n), .i_push(push), .i_data(din), .i_pop(pop),
        .o_data(f_data), .i_afull_thr(afull_thr), .i_aempty_thr(aempty_thr),
        .i_clr_err(clr_err), .o_full(f_full), .o_empty(f_empty),
        .o_almost_full(f_af), .o_almost_empty(f_ae), .o_level(f_level),
        .o_overflow(f_ovf), .o_underflow(f_udf)
`ifdef FIFO_WATERMARK_EN
        , .o_max_level(f_max)
`endif
    );

    fifo_prog_sync #(.DEPTH(DEPTH), .DATA_WIDTH(8), .FWFT(0)) dut_rg (
        .i_clk(clk), .i_rst_n(rst_n), .i_push(push), .i_data(din), .i_pop(pop),
        .o_data(r_data), .i_afull_thr(afull_thr), .i_aempty_thr(aempty_thr),
        .i_clr_err(clr_err), .o_full(r_full), .o_empty(r_empty),
        .o_almost_full(r_af), .o_almost_empty(r_ae), .o_level(r_level),
        .o_overflow(r_ovf), .o_underflow(r_udf)
`ifdef FIFO_WATERMARK_EN
        , .o_max_level(r_max)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_head();
        return (mq.size() > 0) ? mq[0] : 8'h00;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_reg = 8'h00;
`ifdef FIFO_WATERMARK_EN
        m_max = 0;
`endif
    endtask

    // One clock of stimulus; the model applies the FIFO rules to its queue.
    task automatic drive(input bit p, input logic [7:0] d, input bit q, input bit c);
        int lvl;
        bit pop_ok, push_ok;
        push = p; din = d; pop = q; clr_err = c;
        @(posedge clk);
        lvl     = mq.size();
        pop_ok  = q && (lvl > 0);
        push_ok = p && ((lvl < DEPTH) || pop_ok);
        if (c) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
`ifdef FIFO_WATERMARK_EN
        if (c) m_max = lvl;
        else if (lvl > m_max) m_max = lvl;
`endif
        if (p && !push_ok) m_ovf = 1'b1;
        if (q && !pop_ok) m_udf = 1'b1;
        if (pop_ok) m_reg = mq.pop_front();
        if (push_ok) mq.push_back(d);
        #1;
        push = 1'b0; din = 8'h00; pop = 1'b0; clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; afull_thr = 3'd0; aempty_thr = 3'd1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (f_af !== 1'b1) begin errors++; $display("FAIL rst_afull_thr0: got %0b, expected 1", f_af); end
        afull_thr = 3'd4;
        #1;
        checks++; if (f_level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d, expected 0", f_level); end
        checks++; if ({f_empty, f_full, f_ae, f_af} !== 4'b1010) begin errors++; $display("FAIL rst_flags: got %b, expected 1010", {f_empty, f_full, f_ae, f_af}); end
        checks++; if ({f_ovf, f_udf, r_ovf, r_udf} !== 4'b0000) begin errors++; $display("FAIL rst_errors: got %b, expected 0000", {f_ovf, f_udf, r_ovf, r_udf}); end
        checks++; if ({f_data, r_data} !== 16'h0000) begin errors++; $display("FAIL rst_data: got %h, expected 0000", {f_data, r_data}); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
            checks++; if (f_level !== 3'(i + 1)) begin errors++; $display("FAIL fill_level[%0d]: got %0d, expected %0d", i, f_level, i + 1); end
            checks++; if (f_af !== (i + 1 >= 4)) begin errors++; $display("FAIL fill_afull[%0d]: got %0b, expected %0b", i, f_af, (i + 1 >= 4)); end
            checks++; if (f_full !== (i + 1 == 5)) begin errors++; $display("FAIL fill_full[%0d]: got %0b, expected %0b", i, f_full, (i + 1 == 5)); end
            checks++; if (f_data !== 8'hA1) begin errors++; $display("FAIL fill_head[%0d]: got %h, expected a1", i, f_data); end
        end
        for (int i = 0; i < 5; i++) begin
            checks++; if (f_data !== 8'hA1 + 8'(i)) begin errors++; $display("FAIL drain_fw[%0d]: got %h, expected %h", i, f_data, 8'hA1 + 8'(i)); end
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            checks++; if (r_data !== 8'hA1 + 8'(i)) begin errors++; $display("FAIL drain_reg[%0d]: got %h, expected %h", i, r_data, 8'hA1 + 8'(i)); end
            checks++; if (f_level !== 3'(4 - i)) begin errors++; $display("FAIL drain_level[%0d]: got %0d, expected %0d", i, f_level, 4 - i); end
        end
        checks++; if ({f_empty, f_data, r_data} !== {1'b1, 8'h00, 8'hA5}) begin errors++; $display("FAIL drain_end: got %b %h %h, expected 1 00 a5", f_empty, f_data, r_data); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) drive(1'b1, 8'($urandom_range(0, 254)), 1'b0, 1'b0);
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        checks++; if ({f_ovf, r_ovf} !== 2'b11) begin errors++; $display("FAIL ovf_set: got %b, expected 11", {f_ovf, r_ovf}); end
        checks++; if (f_level !== 3'd5) begin errors++; $display("FAIL ovf_level: got %0d, expected 5", f_level); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if ({f_ovf, r_ovf} !== 2'b00) begin errors++; $display("FAIL ovf_clear: got %b, expected 00", {f_ovf, r_ovf}); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (f_data !== exp_head()) begin errors++; $display("FAIL ovf_drain_fw[%0d]: got %h, expected %h", i, f_data, exp_head()); end
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            checks++; if (r_data !== m_reg) begin errors++; $display("FAIL ovf_drain_reg[%0d]: got %h, expected %h", i, r_data, m_reg); end
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 5; i++) drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        drive(1'b1, 8'hB0, 1'b1, 1'b0);
        checks++; if ({f_level, f_full} !== {3'd5, 1'b1}) begin errors++; $display("FAIL fpp_level: got %0d/%0b, expected 5/1", f_level, f_full); end
        checks++; if (r_data !== 8'h10) begin errors++; $display("FAIL fpp_pop: got %h, expected 10", r_data); end
        checks++; if (f_ovf !== 1'b0) begin errors++; $display("FAIL fpp_no_ovf: got %0b, expected 0", f_ovf); end
        for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (r_data !== 8'hB0) begin errors++; $display("FAIL fpp_fifth: got %h, expected b0", r_data); end
    endtask

    task automatic test_empty_push_pop();
        drive(1'b1, 8'hC3, 1'b1, 1'b0);
        checks++; if ({f_udf, r_udf} !== 2'b11) begin errors++; $display("FAIL epp_udf: got %b, expected 11", {f_udf, r_udf}); end
        checks++; if (f_level !== 3'd1) begin errors++; $display("FAIL epp_level: got %0d, expected 1", f_level); end
        checks++; if (f_data !== 8'hC3) begin errors++; $display("FAIL epp_fw: got %h, expected c3", f_data); end
        checks++; if (r_data !== 8'hB0) begin errors++; $display("FAIL epp_reg_hold: got %h, expected b0", r_data); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (f_udf !== 1'b0) begin errors++; $display("FAIL epp_udf_clear: got %0b, expected 0", f_udf); end
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        checks++; if (r_data !== 8'hC3) begin errors++; $display("FAIL epp_reg_pop: got %h, expected c3", r_data); end
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        checks++; if (f_udf !== 1'b1) begin errors++; $display("FAIL udf_set_beats_clear: got %0b, expected 1", f_udf); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_thresholds();
        drive(1'b1, 8'h21, 1'b0, 1'b0);
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        for (int t = 0; t < 8; t++) begin
            afull_thr = 3'(t); aempty_thr = 3'(7 - t);
            #1;
            checks++; if (f_af !== (mq.size() >= t)) begin errors++; $display("FAIL thr_afull[%0d]: got %0b, expected %0b", t, f_af, (mq.size() >= t)); end
            checks++; if (f_ae !== (mq.size() <= 7 - t)) begin errors++; $display("FAIL thr_aempty[%0d]: got %0b, expected %0b", t, f_ae, (mq.size() <= 7 - t)); end
        end
        afull_thr = 3'd4; aempty_thr = 3'd1;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

`ifdef FIFO_WATERMARK_EN
    task automatic test_watermark();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b1, 8'h33, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (f_max !== 3'd3) begin errors++; $display("FAIL wm_peak: got %0d, expected 3", f_max); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (f_max !== 3'd2) begin errors++; $display("FAIL wm_clear: got %0d, expected 2", f_max); end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
    endtask
`endif

    task automatic test_random();
        int pw;
        for (int n = 0; n < 600; n++) begin
            if (n % 50 == 0) pw = $urandom_range(1, 9);
            if (n % 17 == 0) begin
                afull_thr = 3'($urandom_range(0, 7));
                aempty_thr = 3'($urandom_range(0, 7));
            end
            drive($urandom_range(0, 9) < pw, 8'($urandom), $urandom_range(0, 9) >= pw - 1,
                  $urandom_range(0, 15) == 0);
            checks++; if ({f_level, r_level} !== {3'(mq.size()), 3'(mq.size())}) begin errors++; $display("FAIL rnd_level[%0d]: got %0d/%0d, expected %0d", n, f_level, r_level, mq.size()); end
            checks++; if ({f_full, f_empty, f_af, f_ae} !== {mq.size() == DEPTH, mq.size() == 0, mq.size() >= int'(afull_thr), mq.size() <= int'(aempty_thr)}) begin errors++; $display("FAIL rnd_flags[%0d]: got %b at level %0d", n, {f_full, f_empty, f_af, f_ae}, mq.size()); end
            checks++; if ({r_full, r_empty, r_af, r_ae} !== {f_full, f_empty, f_af, f_ae} || {r_full, r_empty} !== {mq.size() == DEPTH, mq.size() == 0}) begin errors++; $display("FAIL rnd_flags_reg[%0d]: got %b", n, {r_full, r_empty, r_af, r_ae}); end
            checks++; if ({f_ovf, f_udf, r_ovf, r_udf} !== {m_ovf, m_udf, m_ovf, m_udf}) begin errors++; $display("FAIL rnd_err[%0d]: got %b, expected %b", n, {f_ovf, f_udf, r_ovf, r_udf}, {m_ovf, m_udf, m_ovf, m_udf}); end
            checks++; if (f_data !== exp_head()) begin errors++; $display("FAIL rnd_fw[%0d]: got %h, expected %h", n, f_data, exp_head()); end
            checks++; if (r_data !== m_reg) begin errors++; $display("FAIL rnd_reg[%0d]: got %h, expected %h", n, r_data, m_reg); end
`ifdef FIFO_WATERMARK_EN
            checks++; if ({f_max, r_max} !== {3'(m_max), 3'(m_max)}) begin errors++; $display("FAIL rnd_max[%0d]: got %0d/%0d, expected %0d", n, f_max, r_max, m_max); end
`endif
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({f_level, f_empty} !== {3'd0, 1'b1}) begin errors++; $display("FAIL midrst_level: got %0d/%0b, expected 0/1", f_level, f_empty); end
        checks++; if ({f_data, r_data} !== 16'h0000) begin errors++; $display("FAIL midrst_data: got %h, expected 0000", {f_data, r_data}); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        checks++; if ({f_level, f_data} !== {3'd1, 8'h5A}) begin errors++; $display("FAIL midrst_push: got %0d/%h, expected 1/5a", f_level, f_data); end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if ({r_data, f_empty} !== {8'h5A, 1'b1}) begin errors++; $display("FAIL midrst_pop: got %h/%0b, expected 5a/1", r_data, f_empty); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_thresholds();
`ifdef FIFO_WATERMARK_EN
        test_watermark();
`endif
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fifo_prog_sync
